fp_mult_seq: RTL and testbench

- Parametrised, sequential IEEE-754-style floating-point multiplier. Successor to the single-precision combinational multiplier.
- Generic exponent and mantissa widths; the default configuration is binary32.
- Adds a valid/ready handshake on both sides, a multi-cycle shift-add significand multiplier, round-to-nearest-even, special-value handling and exception flags.
- Sits between operand-issue logic and a result consumer; one operation in flight at a time.

---
 rtl/fp_mult_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_fp_mult_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754-style floating-point multiplier.
// Operands are classified, normal significands are multiplied with a
// one-bit-per-cycle shift-add loop, then normalised and rounded to nearest
// even. NaN, infinity and zero operands bypass the multiplier. Denormal
// inputs are treated as signed zero and no denormal result is produced.
module fp_mult_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   product,
    output logic [3:0]             flags
);

    // Handshake: an operand pair is taken on a rising edge where
    // in_valid && in_ready; a result is consumed on a rising edge where
    // out_valid && out_ready. Only one operation is in flight, so in_ready
    // is high only in IDLE and product/flags are frozen while out_valid waits.

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 1;           // significand incl. hidden bit
    localparam int PW   = 2 * SW;              // full product width
    localparam int EW2  = EXP_W + 2;           // signed working exponent
    localparam int CW   = $clog2(MAN_W + 2);   // multiplier cycle counter
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_MULT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sign_q, sign_d;
    logic [EW2-1:0]   exp_sum_q, exp_sum_d;
    logic [SW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     product_q, product_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    // Operand field decode of the registered operands
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_snan, b_snan;
    logic             a_inf, b_inf, a_zero, b_zero;
    logic             res_sign;

    assign ea       = a_q[W-2:MAN_W];
    assign eb       = b_q[W-2:MAN_W];
    assign fa       = a_q[MAN_W-1:0];
    assign fb       = b_q[MAN_W-1:0];
    assign a_nan    = (&ea) && (|fa);
    assign b_nan    = (&eb) && (|fb);
    assign a_snan   = a_nan && !fa[MAN_W-1];
    assign b_snan   = b_nan && !fb[MAN_W-1];
    assign a_inf    = (&ea) && !(|fa);
    assign b_inf    = (&eb) && !(|fb);
    assign a_zero   = !(|ea);                  // denormals flush to zero here
    assign b_zero   = !(|eb);
    assign res_sign = a_q[W-1] ^ b_q[W-1];

    // One shift-add step: add multiplicand into the upper half when the
    // current multiplier bit (acc LSB) is set, then shift right by one.
    logic [SW:0] mult_sum;
    assign mult_sum = {1'b0, acc_q[PW-1:SW]} + {1'b0, (acc_q[0] ? mcand_q : {SW{1'b0}})};

    logic [MAN_W-1:0] rnd_frac;
    logic [MAN_W:0]   frac_r;
    logic             guard, sticky, round_up, rnd_inexact;
    logic [EW2-1:0]   e_rnd;
    logic [W-1:0]     rnd_product;
    logic [3:0]       rnd_flags;

    // Normalise, round to nearest even and range-check the finished product
    always_comb begin
        if (acc_q[PW-1]) begin
            rnd_frac = acc_q[PW-2:SW];
            guard    = acc_q[SW-1];
            sticky   = |acc_q[SW-2:0];
        end else begin
            rnd_frac = acc_q[PW-3:SW-1];
            guard    = acc_q[SW-2];
            sticky   = |acc_q[SW-3:0];
        end
        round_up    = guard & (sticky | rnd_frac[0]);
        // The hidden bit is always 1, so a carry out of the fraction means
        // the significand reached 2.0 and renormalises to 1.0 (fraction 0).
        frac_r      = {1'b0, rnd_frac} + {{MAN_W{1'b0}}, round_up};
        e_rnd       = exp_sum_q + EW2'(acc_q[PW-1]) + EW2'(frac_r[MAN_W]);
        rnd_inexact = guard | sticky;
        if ($signed(e_rnd) >= $signed(EW2'(EMAX))) begin
            rnd_product = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags   = 4'b0101;
        end else if ($signed(e_rnd) < $signed(EW2'(1))) begin
            rnd_product = {sign_q, {(W-1){1'b0}}};
            rnd_flags   = 4'b0011;
        end else begin
            rnd_product = {sign_q, e_rnd[EXP_W-1:0], frac_r[MAN_W-1:0]};
            rnd_flags   = {3'b000, rnd_inexact};
        end
    end

    // Next-state and next-datapath logic for the whole operation sequence
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        exp_sum_d   = exp_sum_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        flags_d     = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d       = a;
                    b_d       = b;
                    product_d = '0;
                    flags_d   = '0;
                    state_d   = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                sign_d = res_sign;
                if (a_nan || b_nan) begin
                    product_d = QNAN;
                    flags_d   = {(a_snan || b_snan), 3'b000};
                    state_d   = S_DONE;
                end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                    product_d = QNAN;
                    flags_d   = 4'b1000;
                    state_d   = S_DONE;
                end else if (a_inf || b_inf) begin
                    product_d = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d   = 4'b0000;
                    state_d   = S_DONE;
                end else if (a_zero || b_zero) begin
                    product_d = {res_sign, {(W-1){1'b0}}};
                    flags_d   = 4'b0000;
                    state_d   = S_DONE;
                end else begin
                    mcand_d   = {1'b1, fa};
                    acc_d     = {{SW{1'b0}}, 1'b1, fb};
                    exp_sum_d = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
                    cnt_d     = '0;
                    state_d   = S_MULT;
                end
            end
            S_MULT: begin
                acc_d = {mult_sum, acc_q[SW-1:1]};
                if (cnt_q == CW'(MAN_W)) begin
                    cnt_d   = '0;
                    state_d = S_ROUND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ROUND: begin
                product_d = rnd_product;
                flags_d   = rnd_flags;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // out_valid is raised one cycle after entering DONE and dropped on
        // the consuming edge.
        out_valid_d = (state_q == S_DONE) && !(out_valid_q && out_ready);
        in_ready_d  = (state_d == S_IDLE);
    end

    // State and datapath registers; reset aborts any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            exp_sum_q   <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            exp_sum_q   <= exp_sum_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Bench for fp_mult_seq: a binary32 and a binary16 instance, directed
// vectors with hand-computed results plus random operands checked against
// an arithmetic reference model.
module tb_fp_mult_seq;

    typedef longint unsigned u64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] a32, b32, product32;
    logic [3:0]  flags32;
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, product16;
    logic [3:0]  flags16;

    fp_mult_seq dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .product(product32), .flags(flags32)
    );

    fp_mult_seq #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .product(product16), .flags(flags16)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [35:0] exp_q[$];   // {flags, product}

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Reference: exact integer product of the significands, then rounding
    // by comparing the discarded remainder against one half ulp.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int ew, input int mw);
        u64 emax, bias, ea, eb, fa, fb, fmask, qnan, p, q, rem, half, sbit;
        longint e;
        int sh;
        bit an, bn, asn, bsn, ai, bi, az, bz, s, inx;
        fmask = (u64'(1) << mw) - 1;
        emax  = (u64'(1) << ew) - 1;
        bias  = (u64'(1) << (ew - 1)) - 1;
        ea = (u64'(a) >> mw) & emax;
        eb = (u64'(b) >> mw) & emax;
        fa = u64'(a) & fmask;
        fb = u64'(b) & fmask;
        s  = a[ew+mw] ^ b[ew+mw];
        an  = (ea == emax) && (fa != 0);
        bn  = (eb == emax) && (fb != 0);
        asn = an && (((fa >> (mw - 1)) & 1) == 0);
        bsn = bn && (((fb >> (mw - 1)) & 1) == 0);
        ai  = (ea == emax) && (fa == 0);
        bi  = (eb == emax) && (fb == 0);
        az  = (ea == 0);
        bz  = (eb == 0);
        qnan = (emax << mw) | (u64'(1) << (mw - 1));
        sbit = u64'(s) << (ew + mw);
        if (an || bn) return {((asn || bsn) ? 4'b1000 : 4'b0000), 32'(qnan)};
        if ((ai && bz) || (bi && az)) return {4'b1000, 32'(qnan)};
        if (ai || bi) return {4'b0000, 32'(sbit | (emax << mw))};
        if (az || bz) return {4'b0000, 32'(sbit)};
        p  = (fa + fmask + 1) * (fb + fmask + 1);
        e  = longint'(ea) + longint'(eb) - longint'(bias);
        sh = mw;
        if (p >= (u64'(1) << (2 * mw + 1))) begin
            sh = mw + 1;
            e++;
        end
        q    = p >> sh;
        rem  = p & ((u64'(1) << sh) - 1);
        half = u64'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (u64'(1) << (mw + 1))) begin
            q = q >> 1;
            e++;
        end
        inx = (rem != 0);
        if (e >= longint'(emax)) return {4'b0101, 32'(sbit | (emax << mw))};
        if (e <= 0) return {4'b0011, 32'(sbit)};
        return {3'b000, inx, 32'(sbit | (u64'(e) << mw) | (q & fmask))};
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b,
                                      input int ew, input int mw);
        u64 emax, ea, eb;
        emax = (u64'(1) << ew) - 1;
        ea = (u64'(a) >> mw) & emax;
        eb = (u64'(b) >> mw) & emax;
        return (ea == 0) || (ea == emax) || (eb == 0) || (eb == emax);
    endfunction

    function automatic logic [31:0] rand_op(input int ew, input int mw);
        u64 emax, bias, fmask, ex, fr;
        int k;
        emax  = (u64'(1) << ew) - 1;
        bias  = (u64'(1) << (ew - 1)) - 1;
        fmask = (u64'(1) << mw) - 1;
        fr = u64'($urandom) & fmask;
        k  = $urandom_range(0, 9);
        case (k)
            0: begin
                case ($urandom_range(0, 4))
                    0: begin ex = 0;    fr = 0; end
                    1: begin ex = emax; fr = 0; end
                    2: begin ex = emax; fr = fr | (u64'(1) << (mw - 1)); end
                    3: begin ex = emax; fr = (fr & (fmask >> 1)) | 1; end
                    default: begin ex = 0; fr = fr | 1; end
                endcase
            end
            1: ex = u64'($urandom_range(1, 6));
            2: ex = u64'($urandom_range(32'(emax) - 6, 32'(emax) - 1));
            default: ex = u64'($urandom_range(32'(bias) - 10, 32'(bias) + 10));
        endcase
        return 32'((u64'($urandom_range(0, 1)) << (ew + mw)) | (ex << mw) | fr);
    endfunction

    // ---------------- driver ----------------
    function automatic logic cur_ov(input bit h);
        return h ? out_valid16 : out_valid32;
    endfunction
    function automatic logic cur_rdy(input bit h);
        return h ? in_ready16 : in_ready32;
    endfunction
    function automatic logic [31:0] cur_prod(input bit h);
        return h ? {16'h0, product16} : product32;
    endfunction
    function automatic logic [3:0] cur_flags(input bit h);
        return h ? flags16 : flags32;
    endfunction

    task automatic drive_in(input bit h, input logic v, input logic [31:0] av, input logic [31:0] bv);
        if (h) begin
            in_valid16 = v; a16 = av[15:0]; b16 = bv[15:0];
        end else begin
            in_valid32 = v; a32 = av; b32 = bv;
        end
    endtask

    task automatic run_op(input string tag, input bit h, input logic [31:0] av, input logic [31:0] bv,
                          input logic [35:0] expv, input int exp_lat, input int hold);
        logic [35:0] e;
        int  lat;
        bit  got, rdy_high, stable;
        exp_q.push_back(expv);
        @(negedge clk);
        drive_in(h, 1'b1, av, bv);
        check_val({tag, "_in_ready_idle"}, cur_rdy(h), 1);
        @(posedge clk);
        #1;
        drive_in(h, 1'b0, 32'h0, 32'h0);
        lat = 0; got = 0; rdy_high = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cur_rdy(h)) rdy_high = 1;
            if (cur_ov(h)) got = 1;
        end
        check_val({tag, "_timeout"}, got, 1);
        e = exp_q.pop_front();
        if (!got) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
        end else begin
            check_val({tag, "_latency"}, lat, exp_lat);
            check_val({tag, "_in_ready_busy"}, rdy_high, 0);
            check_val({tag, "_product"}, cur_prod(h), e[31:0]);
            check_val({tag, "_flags"}, cur_flags(h), e[35:32]);
            if (hold > 0) begin
                stable = 1;
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    drive_in(h, 1'b1, ~av, bv);
                    @(posedge clk);
                    #1;
                    if (!cur_ov(h) || cur_rdy(h) || cur_prod(h) != e[31:0] || cur_flags(h) != e[35:32])
                        stable = 0;
                end
                check_val({tag, "_hold_stable"}, stable, 1);
            end
            @(negedge clk);
            drive_in(h, 1'b0, 32'h0, 32'h0);
            if (h) out_ready16 = 1'b1; else out_ready32 = 1'b1;
            @(posedge clk);
            #1;
            out_ready16 = 1'b0;
            out_ready32 = 1'b0;
            check_val({tag, "_release"}, {cur_ov(h), cur_rdy(h)}, 2'b01);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ra, rb;
        bit quiet;
        rst_n = 1'b0;
        in_valid32 = 0; a32 = 0; b32 = 0; out_ready32 = 0;
        in_valid16 = 0; a16 = 0; b16 = 0; out_ready16 = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset32", {in_ready32, out_valid32, flags32, product32}, {1'b1, 1'b0, 4'h0, 32'h0});
        check_val("reset16", {in_ready16, out_valid16, flags16, product16}, {1'b1, 1'b0, 4'h0, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;

        // binary32 directed vectors
        run_op("norm_85x45",  0, 32'h42AA4000, 32'h42348000, {4'b0000, 32'h45701440}, 27, 10);
        run_op("neg_x_neg",   0, 32'hC0B00000, 32'hC1280000, {4'b0000, 32'h42670000}, 27, 0);
        run_op("inexact",     0, 32'h3F800001, 32'h3F800001, {4'b0001, 32'h3F800002}, 27, 0);
        run_op("times_one",   0, 32'h42348000, 32'h3F800000, {4'b0000, 32'h42348000}, 27, 0);
        run_op("tie_odd_up",  0, 32'h3F800001, 32'h3FC00000, {4'b0001, 32'h3FC00002}, 27, 0);
        run_op("inf_x_zero",  0, 32'h7F800000, 32'h00000000, {4'b1000, 32'h7FC00000}, 2, 3);
        run_op("x_negzero",   0, 32'h42AA4000, 32'h80000000, {4'b0000, 32'h80000000}, 2, 0);
        run_op("snan",        0, 32'h7FA00000, 32'h3F800000, {4'b1000, 32'h7FC00000}, 2, 0);
        run_op("qnan_x_inf",  0, 32'h7FC00000, 32'h7F800000, {4'b0000, 32'h7FC00000}, 2, 0);
        run_op("inf_x_neg",   0, 32'h7F800000, 32'hC0000000, {4'b0000, 32'hFF800000}, 2, 0);
        run_op("overflow",    0, 32'h7F000000, 32'h7F000000, {4'b0101, 32'h7F800000}, 27, 0);
        run_op("underflow",   0, 32'h00800000, 32'h3F000000, {4'b0011, 32'h00000000}, 27, 0);
        run_op("denorm_in",   0, 32'h00000001, 32'h40000000, {4'b0000, 32'h00000000}, 2, 0);

        // binary16 directed vectors
        run_op("h_5x3",       1, 32'h4500, 32'h4200, {4'b0000, 32'h4B80}, 14, 0);
        run_op("h_overflow",  1, 32'h7800, 32'h7800, {4'b0101, 32'h7C00}, 14, 0);

        // reset during the multiply loop
        @(negedge clk);
        drive_in(0, 1'b1, 32'h42AA4000, 32'h42348000);
        @(posedge clk);
        #1;
        drive_in(0, 1'b0, 32'h0, 32'h0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset", {out_valid32, in_ready32, flags32, product32}, {1'b0, 1'b1, 4'h0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid32 || !in_ready32) quiet = 0;
        end
        check_val("aborted_no_result", quiet, 1);
        run_op("after_reset", 0, 32'h42AA4000, 32'h42348000, {4'b0000, 32'h45701440}, 27, 0);

        // random stimulus against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = rand_op(8, 23);
            rb = rand_op(8, 23);
            run_op($sformatf("rnd32_%0d_%08h_%08h", i, ra, rb), 0, ra, rb, ref_mul(ra, rb, 8, 23),
                   is_special(ra, rb, 8, 23) ? 2 : 27, $urandom_range(0, 2));
        end
        for (int i = 0; i < 20; i++) begin
            ra = rand_op(5, 10);
            rb = rand_op(5, 10);
            run_op($sformatf("rnd16_%0d_%04h_%04h", i, ra[15:0], rb[15:0]), 1, ra, rb, ref_mul(ra, rb, 5, 10),
                   is_special(ra, rb, 5, 10) ? 2 : 14, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
